// File: rtl/apb_arb_pkg.sv
// Shared types and default sizes for the APB request arbiter slice.
package apb_arb_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = '0;
      j   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         j   = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : sum[IDX_W-1:0];
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among NUM_REQ requesters (IDLE -> ISSUE -> WAIT).
// Optional WAIT watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                                 pclk,
   input  logic                                 preset,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
   input  logic [NUM_REQ-1:0]                   wr_rd_i,
   output logic [NUM_REQ-1:0]                   gnt_o,
   output logic [NUM_REQ-1:0]                   done_o,
   output logic [DATA_WIDTH-1:0]                rdata_o,
   output logic                                 err_o,
   output logic                                 trans_o,
   output logic [ADDR_WIDTH-1:0]                addr_o,
   output logic [DATA_WIDTH-1:0]                wdata_o,
   output logic                                 wr_rd_o,
   input  logic                                 m_done_i,
   input  logic [DATA_WIDTH-1:0]                m_rdata_i,
   input  logic                                 m_err_i
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
      $error("apb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
   end

   arb_state_t             state, state_nxt;
   logic [NUM_REQ-1:0]     pick_gnt, gnt_q;
   logic [IDX_W-1:0]       pick_idx, idx_q, ptr_q;
   logic                   pick_any, timeout, complete;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic                   wr_rd_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req (req_i),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Winner's request is frozen at the IDLE edge; later input changes are ignored.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_rd_q <= 1'b0;
      end else begin
         if (state == IDLE && pick_any) begin
            gnt_q   <= pick_gnt;
            idx_q   <= pick_idx;
            addr_q  <= addr_i[pick_idx];
            wdata_q <= wdata_i[pick_idx];
            wr_rd_q <= wr_rd_i[pick_idx];
         end
         if (complete) ptr_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wd_cnt;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset)              wd_cnt <= '0;
      else if (state != WAIT)  wd_cnt <= '0;
      else                     wd_cnt <= wd_cnt + CNT_W'(1);
   end

   assign timeout = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      gnt_o     = '0;
      done_o    = '0;
      trans_o   = 1'b0;
      rdata_o   = '0;
      err_o     = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: if (pick_any) state_nxt = ISSUE;
         ISSUE: begin
            gnt_o     = gnt_q;
            trans_o   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A real completion wins over a coincident watchdog expiry.
            if (m_done_i || timeout) begin
               complete  = 1'b1;
               done_o    = gnt_q;
               err_o     = m_done_i ? m_err_i : 1'b1;
               rdata_o   = (m_done_i && !wr_rd_q) ? m_rdata_i : '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign wr_rd_o = wr_rd_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_apb_req_arbiter;

   localparam int N   = 4;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic                  pclk = 1'b0;
   logic                  preset;
   logic [N-1:0]          req_i;
   logic [N-1:0][AW-1:0]  addr_i;
   logic [N-1:0][DW-1:0]  wdata_i;
   logic [N-1:0]          wr_rd_i;
   logic [N-1:0]          gnt_o, done_o;
   logic [DW-1:0]         rdata_o;
   logic                  err_o, trans_o, wr_rd_o;
   logic [AW-1:0]         addr_o;
   logic [DW-1:0]         wdata_o;
   logic                  m_done_i;
   logic [DW-1:0]         m_rdata_i;
   logic                  m_err_i;

   int            checks = 0;
   int            errors = 0;
   int            mptr;
   logic [DW-1:0] mem [0:255];

   always #5 pclk = ~pclk;

   apb_req_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
   ) dut (
      .pclk(pclk), .preset(preset), .req_i(req_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .wr_rd_i(wr_rd_i), .gnt_o(gnt_o), .done_o(done_o),
      .rdata_o(rdata_o), .err_o(err_o), .trans_o(trans_o), .addr_o(addr_o),
      .wdata_o(wdata_o), .wr_rd_o(wr_rd_o), .m_done_i(m_done_i),
      .m_rdata_i(m_rdata_i), .m_err_i(m_err_i)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester at or above p, wrapping.
   function automatic int model_pick(input logic [N-1:0] req, input int p);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         r = req >> ((p + i) % N);
         if (r[0]) return (p + i) % N;
      end
      return 0;
   endfunction

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] v;
      v = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt"},   gnt_o,   0);
      chk({tag, "_done"},  done_o,  0);
      chk({tag, "_trans"}, trans_o, 0);
      chk({tag, "_addr"},  addr_o,  0);
      chk({tag, "_wdata"}, wdata_o, 0);
      chk({tag, "_wr"},    wr_rd_o, 0);
      chk({tag, "_rdata"}, rdata_o, 0);
      chk({tag, "_err"},   err_o,   0);
   endtask

   // One full transfer starting in IDLE with req_i already driven.
   task automatic run_one(input int lat, input bit err, input bit early_done,
                          output logic [N-1:0] o_gnt, output logic [DW-1:0] o_rdata,
                          output logic o_err);
      int            w;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, er;
      bit            ew;
      logic [N-1:0]  eg;
      w  = model_pick(req_i, mptr);
      eg = onehot(w);
      ea = addr_i[w];
      ed = wdata_i[w];
      ew = wr_rd_i[w];
      chk("idle_gnt", gnt_o, 0);
      chk("idle_trans", trans_o, 0);
      tick();
      o_gnt = gnt_o;
      chk("issue_gnt", gnt_o, eg);
      chk("issue_trans", trans_o, 1);
      chk("issue_addr", addr_o, ea);
      chk("issue_wdata", wdata_o, ed);
      chk("issue_wr", wr_rd_o, ew);
      m_done_i  = early_done;
      m_err_i   = 1'b1;
      m_rdata_i = $urandom;
      addr_i    = $urandom;
      wdata_i   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("issue_ignore_done", done_o, 0);
      tick();
      m_done_i = 1'b0;
      m_err_i  = 1'b0;
      for (int k = 0; k < lat; k++) begin
         #1;
         chk("wait_done", done_o, 0);
         chk("wait_trans", trans_o, 0);
         chk("wait_gnt", gnt_o, 0);
         chk("wait_addr", addr_o, ea);
         chk("wait_wdata", wdata_o, ed);
         tick();
      end
      m_rdata_i = ew ? DW'($urandom | 1) : mem[addr_o];
      er        = ew ? '0 : mem[ea];
      m_err_i   = err;
      m_done_i  = 1'b1;
      #1;
      chk("cmpl_done", done_o, eg);
      chk("cmpl_err", err_o, err);
      chk("cmpl_rdata", rdata_o, er);
      o_rdata = rdata_o;
      o_err   = err_o;
      if (wr_rd_o) mem[addr_o] = wdata_o;
      mptr = (w + 1) % N;
      tick();
      m_done_i  = 1'b0;
      m_err_i   = 1'b0;
      m_rdata_i = '0;
   endtask

   initial begin
      logic [N-1:0]  g;
      logic [DW-1:0] r;
      logic          e;
      int            w, k;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      preset    = 1'b0;
      req_i     = '1;
      addr_i    = $urandom;
      wdata_i   = {$urandom, $urandom, $urandom, $urandom};
      wr_rd_i   = '1;
      m_done_i  = 1'b1;
      m_rdata_i = 32'hFFFF_FFFF;
      m_err_i   = 1'b1;
      #1 preset = 1'b1;
      #1 check_all_zero("reset_async");
      tick();
      tick();
      check_all_zero("reset_held");
      req_i     = '0;
      m_done_i  = 1'b0;
      m_rdata_i = '0;
      m_err_i   = 1'b0;
      preset    = 1'b0;
      mptr      = 0;

      // No request: stays idle, bus completion ignored.
      m_done_i = 1'b1;
      tick();
      chk("noreq_gnt", gnt_o, 0);
      chk("noreq_done", done_o, 0);
      chk("noreq_trans", trans_o, 0);
      m_done_i = 1'b0;
      tick();

      // Single write from requester 0.
      req_i = 4'b0001; addr_i[0] = 8'h10; wdata_i[0] = 32'hA5A5_A5A5; wr_rd_i[0] = 1'b1;
      run_one(2, 1'b0, 1'b0, g, r, e);
      chk("wr_gnt", g, 4'b0001);
      chk("wr_mem10", mem[8'h10], 32'hA5A5_A5A5);

      // Read-back from requester 2.
      req_i = 4'b0100; addr_i[2] = 8'h10; wr_rd_i = 4'b1011;
      run_one(1, 1'b0, 1'b0, g, r, e);
      chk("rd_gnt", g, 4'b0100);
      chk("rd_rdata", r, 32'hA5A5_A5A5);
      chk("rd_err", e, 0);

      // Bring pointer to 0, then fairness with all requesters held.
      req_i = 4'b1000;
      run_one(0, 1'b0, 1'b0, g, r, e);
      chk("ptr_align_gnt", g, 4'b1000);
      req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         addr_i  = $urandom;
         wdata_i = {$urandom, $urandom, $urandom, $urandom};
         wr_rd_i = $urandom;
         run_one(int'($urandom_range(0, 3)), 1'b0, 1'b0, g, r, e);
         chk("fair_order", g, onehot(i % N));
      end

      // Slave error, then a normal transfer.
      run_one(1, 1'b1, 1'b0, g, r, e);
      chk("serr_gnt", g, 4'b0010);
      chk("serr_err", e, 1);
      run_one(0, 1'b0, 1'b0, g, r, e);
      chk("after_err_gnt", g, 4'b0100);
      chk("after_err_err", e, 0);

      // Reset during WAIT: silent abort, pointer back to 0.
      addr_i[3] = 8'h5A; wdata_i[3] = 32'h1234_5678; wr_rd_i[3] = 1'b1;
      tick();
      chk("rst_issue_gnt", gnt_o, 4'b1000);
      tick();
      chk("rst_wait_addr", addr_o, 8'h5A);
      preset   = 1'b1;
      m_done_i = 1'b1;
      #1 check_all_zero("rst_wait");
      tick();
      tick();
      chk("rst_hold_done", done_o, 0);
      chk("rst_hold_trans", trans_o, 0);
      preset   = 1'b0;
      m_done_i = 1'b0;
      mptr     = 0;
      run_one(1, 1'b0, 1'b0, g, r, e);
      chk("rst_next_gnt", g, 4'b0001);

`ifdef APB_ARB_TIMEOUT_EN
      // Watchdog expiry with the bus silent.
      w = model_pick(req_i, mptr);
      wr_rd_i[w] = 1'b0;
      tick();
      chk("tmo_issue_gnt", gnt_o, onehot(w));
      tick();
      m_rdata_i = 32'hDEAD_BEEF;
      k = 0;
      for (int c = 0; c < TMO + 8; c++) begin
         if (done_o != '0) break;
         tick();
         k++;
      end
      chk("tmo_cycles", k, TMO);
      chk("tmo_done", done_o, onehot(w));
      chk("tmo_err", err_o, 1);
      chk("tmo_rdata", rdata_o, 0);
      mptr = (w + 1) % N;
      tick();

      // Bus completion coinciding with expiry takes priority.
      w = model_pick(req_i, mptr);
      wr_rd_i[w] = 1'b0;
      tick();
      tick();
      for (int c = 0; c < TMO; c++) begin
         chk("tmo_pri_wait", done_o, 0);
         tick();
      end
      m_done_i = 1'b1; m_err_i = 1'b0; m_rdata_i = 32'h0BAD_F00D;
      #1;
      chk("tmo_pri_done", done_o, onehot(w));
      chk("tmo_pri_err", err_o, 0);
      chk("tmo_pri_rdata", rdata_o, 32'h0BAD_F00D);
      mptr = (w + 1) % N;
      tick();
      m_done_i = 1'b0; m_rdata_i = '0;
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 40; i++) begin
         req_i   = N'($urandom_range(1, 15));
         addr_i  = $urandom;
         wdata_i = {$urandom, $urandom, $urandom, $urandom};
         wr_rd_i = $urandom;
         run_one(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), g, r, e);
      end

      req_i = '0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one APB master (2..8).
REQ-002 Parameter ADDR_WIDTH, default 8: address width of each request.
REQ-003 Parameter DATA_WIDTH, default 32: write and read data width.
REQ-004 Parameter TIMEOUT, default 16: watchdog limit in WAIT, in pclk cycles.
REQ-005 pclk  in  1  sole clock; all logic on the rising edge.
REQ-006 preset  in  1  asynchronous, active-high reset.
REQ-007 req_i  in  NUM_REQ  per-requester transaction request, level-held.
REQ-008 addr_i  in  NUM_REQ x ADDR_WIDTH  per-requester address.
REQ-009 wdata_i  in  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-010 wr_rd_i  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
REQ-011 gnt_o  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-012 done_o  out  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-013 rdata_o  out  DATA_WIDTH  read data; valid only while done_o is non-zero.
REQ-014 err_o  out  1  error status; valid only while done_o is non-zero.
REQ-015 trans_o, addr_o, wdata_o, wr_rd_o  out  1/ADDR_WIDTH/DATA_WIDTH/1  drive the APB master's trans_i, addr_i, wdata_i and wr_rd_i.
REQ-016 m_done_i  in  1  transfer completion, pselx & penable & pready from the APB bus.
REQ-017 m_rdata_i / m_err_i  in  DATA_WIDTH/1  APB master rdata_o and trans_err_o.

Function
REQ-018 The FSM SHALL use the states IDLE, ISSUE and WAIT.
REQ-019 In IDLE with any req_i bit set, the block SHALL choose the winner round-robin, searching upward from ptr and wrapping.
REQ-020 On that IDLE edge the block SHALL register the winner's addr, wdata and wr_rd, then go to ISSUE.
REQ-021 In ISSUE, for exactly one cycle, gnt_o[winner] and trans_o SHALL be 1 and addr_o/wdata_o/wr_rd_o SHALL show the latched values; next state is WAIT.
REQ-022 addr_o, wdata_o and wr_rd_o SHALL hold the latched values through WAIT.
REQ-023 m_done_i SHALL be ignored in IDLE and ISSUE.
REQ-024 In WAIT, when m_done_i = 1:
- done_o[winner] = 1 for one cycle;
- rdata_o = m_rdata_i when wr_rd = 0, else 0;
- err_o = m_err_i;
- ptr = (winner + 1) mod NUM_REQ;
- next state is IDLE.
REQ-025 Minimum occupancy SHALL be 3 cycles per transfer (IDLE, ISSUE, WAIT).
REQ-026 A requester still holding req_i after done_o SHALL be re-arbitrated, with no back-to-back bypass of IDLE.
REQ-027 Changes to req_i, addr_i or wdata_i after capture SHALL have no effect on the transfer in flight.
REQ-028 A requester dropping req_i while not granted SHALL simply be skipped.
REQ-029 With all requesters active, every requester SHALL receive a grant within NUM_REQ arbitrations.

Reset
REQ-030 While preset = 1, the state SHALL be IDLE, ptr 0 and every output 0, with no dependence on pclk.
REQ-031 Reset during ISSUE or WAIT SHALL abort silently, emitting no done_o.
REQ-032 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-033 The macro APB_ARB_TIMEOUT_EN SHALL control the WAIT watchdog.
REQ-034 With APB_ARB_TIMEOUT_EN defined:
- a counter clears on entry to WAIT and increments each WAIT cycle;
- when it reaches TIMEOUT without m_done_i, the block completes as in REQ-024, with err_o = 1 and rdata_o = 0;
- m_done_i arriving in the same cycle as the timeout takes priority.
REQ-035 Without APB_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL be left only on m_done_i.

Structure
REQ-036 The shared package apb_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT) and the default NUM_REQ, ADDR_WIDTH, DATA_WIDTH and TIMEOUT constants.
REQ-037 The sub-module rr_arbiter SHALL implement the combinational round-robin pick (req vector, ptr -> one-hot winner plus index).
REQ-038 apb_req_arbiter SHALL instantiate rr_arbiter once and own the FSM, capture registers, pointer and watchdog.

Verification
REQ-039 Single write: req_i = 0001, addr 0x10, wdata 0xA5A5A5A5, wr_rd 1.
- gnt_o = 0001 one cycle after req_i.
- trans_o high for exactly 1 cycle.
- done_o = 0001 on m_done_i; memory[0x10] = 0xA5A5A5A5.
REQ-040 Read-back: requester 2 reads addr 0x10 -> done_o = 0100, rdata_o = 0xA5A5A5A5, err_o = 0.
REQ-041 Fairness: req_i = 1111 held continuously -> grant order 0, 1, 2, 3, 0; no requester granted twice before every other requester is granted once.
REQ-042 Slave error: m_err_i = 1 in the completion cycle -> err_o = 1 together with done_o of the owning requester; the next grant proceeds normally.
REQ-043 Reset mid-WAIT: assert preset for 2 cycles during WAIT -> all outputs 0 immediately, no done_o, and the next grant goes to requester 0.
REQ-044 Timeout (APB_ARB_TIMEOUT_EN defined, TIMEOUT = 16): m_done_i held low -> done_o pulses 16 cycles after WAIT entry, with err_o = 1 and rdata_o = 0.
